// File: rtl/nand_bank_filt.sv
// nand_bank_filt
// ----------------------------------------------------------------------------
// Bank of NCH independent NIN-input NAND channels. Each channel has an
// enable, an optional input synchroniser and a deglitch filter. A channel's
// output follows its NAND result only after that result has disagreed with the
// output for FILT consecutive enabled edges. Every output comes from a flop.
//
// Build option:
//   NAND_BANK_SYNC_EN  defined   -> a 2-flop synchroniser sits on every input
//                                   bit, for inputs asynchronous to CELCLK.
//                      undefined -> the NAND is taken straight from i. In this
//                                   case the inputs must be synchronous to
//                                   CELCLK.
//
// Parameters:
//   NCH   number of channels (1..16)
//   NIN   inputs per channel (2..8)
//   FILT  number of consecutive disagreeing edges needed before o follows the
//         NAND result (1..255)
//
// Ports:
//   CELCLK   block clock; all state changes on the rising edge
//   CELRSTN  synchronous active-low reset
//   CELV     supply tie (passed through for netlisting only; no logic)
//   CELG     ground tie (passed through for netlisting only; no logic)
//   SUB      substrate tie (passed through for netlisting only; no logic)
//   i        channel inputs; channel c uses i[c*NIN +: NIN]
//   en       per-channel enable; while low the channel holds o=1
//   o        filtered, registered NAND outputs
//   chg      one-cycle pulse on the edge where the matching o toggles
// ----------------------------------------------------------------------------
module nand_bank_filt #(
    parameter int NCH  = 4,
    parameter int NIN  = 2,
    parameter int FILT = 3
) (
    input  logic               CELCLK,
    input  logic               CELRSTN,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    input  logic [NCH*NIN-1:0] i,
    input  logic [NCH-1:0]     en,
    output logic [NCH-1:0]     o,
    output logic [NCH-1:0]     chg
);

    localparam int            CW       = $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    // The tie pins have no logic function. They are gathered here so the
    // port list stays complete without leaving dangling inputs.
    logic unused_ties;
    assign unused_ties = ^{CELV, CELG, SUB};

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [NIN-1:0] samp;
            logic           raw;
            logic [CW-1:0]  cnt_reg, cnt_next;
            logic           o_reg, o_next;
            logic           chg_reg, chg_next;

`ifdef NAND_BANK_SYNC_EN
            logic [NIN-1:0] s1_reg, s2_reg;

            // The synchroniser keeps sampling while the channel is disabled.
            // Only reset clears it.
            always_ff @(posedge CELCLK) begin
                if (!CELRSTN) begin
                    s1_reg <= '0;
                    s2_reg <= '0;
                end else begin
                    s1_reg <= i[gi*NIN +: NIN];
                    s2_reg <= s1_reg;
                end
            end

            assign samp = s2_reg;
`else
            assign samp = i[gi*NIN +: NIN];
`endif

            assign raw = ~&samp;

            // cnt holds the number of consecutive edges on which raw has
            // disagreed with o. On the FILT-th such edge, o takes the new
            // value and cnt restarts, so cnt never reaches FILT. This means
            // no wrap-around guard is needed.
            always_comb begin
                cnt_next = '0;
                o_next   = o_reg;
                chg_next = 1'b0;
                if (!en[gi]) begin
                    // A forced return to 1 is not a filtered toggle, so it
                    // does not produce a chg pulse.
                    o_next = 1'b1;
                end else if (raw != o_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        o_next   = raw;
                        chg_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge CELCLK) begin
                if (!CELRSTN) begin
                    cnt_reg <= '0;
                    o_reg   <= 1'b1;    // NAND of the all-zero reset inputs
                    chg_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    o_reg   <= o_next;
                    chg_reg <= chg_next;
                end
            end

            assign o[gi]   = o_reg;
            assign chg[gi] = chg_reg;
        end
    endgenerate

endmodule
